// File: rtl/serial_in_stream_pkg.sv
// Shared definitions for the serial receive path: FSM states, stream widths, bit-timing helpers.
// Pure declarations, no logic; the transmitter side can import the same package.
// Timing helpers truncate exactly like integer division so RX and TX agree on the bit period.
package serial_in_stream_pkg;

    // Width of the output stream word and of one serial character
    localparam int unsigned STREAM_WIDTH = 32;
    localparam int unsigned BYTE_WIDTH   = 8;

    // Receiver framing states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit, truncated
    function automatic int unsigned bit_divisor(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Cycles from start-edge detection to the middle of the start bit
    function automatic int unsigned half_divisor(input int unsigned divisor);
        return divisor / 2;
    endfunction

endpackage

// File: rtl/serial_in_stream_fifo.sv
// Generic stb/ack byte buffer: power-of-two depth, extra-MSB pointers for full/empty.
// Latency: a push is visible at the head on the next cycle; a pop exposes the next entry the next cycle.
// Backpressure: push while full without a same-cycle pop is dropped and flagged on overflow.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             overflow,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Same index with differing wrap bit means the buffer has lapped the reader
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a full push is still taken
    assign push_ok  = push && (!full || pop_ok);
    assign overflow = push && full && !pop_ok;
    // Head reads as zero when nothing is buffered so the stream word is clean out of reset
    assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; pointers wrap naturally through the extra MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_in_stream.sv
// 8N1 UART receiver feeding a 32-bit stb/ack stream through a small byte buffer.
// Latency: stb rises one cycle after the stop-bit sample (2-FF sync ahead of decoding).
// Backpressure: bytes queue while ack is low; a full buffer drops the new byte and pulses overrun.
module serial_in_stream
    import serial_in_stream_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    output logic [STREAM_WIDTH-1:0] output_rs232_rx,
    output logic                    output_rs232_rx_stb,
    input  logic                    output_rs232_rx_ack,
    output logic                    framing_error,
    output logic                    overrun
);

    localparam int unsigned DIVISOR = bit_divisor(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF    = half_divisor(DIVISOR);
    localparam int unsigned TW      = $clog2(DIVISOR);

    localparam logic [TW-1:0] LAST_TICK = TW'(DIVISOR - 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(HALF - 1);

    rx_state_t             state;
    rx_state_t             state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic [TW-1:0]         timer;
    logic                  timer_clr;
    logic [2:0]            bit_idx;
    logic                  shift_en;
    logic [BYTE_WIDTH-1:0] shift_reg;
    logic                  push;
    logic                  frame_err;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_overflow;
    logic                  pop;
    logic [BYTE_WIDTH-1:0] head;

    // Two-stage synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes for timer, shifter and buffer
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        shift_en   = 1'b0;
        push       = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Mid-start-bit recheck filters short glitches silently
                if (timer == HALF_TICK) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == LAST_TICK) begin
                    shift_en  = 1'b1;
                    timer_clr = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == LAST_TICK) begin
                    if (rx_s) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not decode as a stream of zero bytes
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timer restarts on every state entry and after each data-bit sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (timer_clr || (state_next != state)) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Data-bit index, held at zero outside DATA so each frame starts at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
        end else if (state != DATA) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // LSB-first shift: each new bit enters at the top and walks down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {rx_s, shift_reg[BYTE_WIDTH-1:1]};
        end
    end

    // Error pulses registered so each lasts exactly one clean cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_err;
            overrun       <= fifo_overflow;
        end
    end

    stream_fifo #(
        .WIDTH (BYTE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_reg),
        .full      (fifo_full),
        .overflow  (fifo_overflow),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty)
    );

    assign output_rs232_rx_stb = !fifo_empty;
    assign pop                 = output_rs232_rx_stb && output_rs232_rx_ack;
    assign output_rs232_rx     = {{(STREAM_WIDTH - BYTE_WIDTH){1'b0}}, head};

endmodule

// File: tb/tb_serial_in_stream.sv
// Directed + randomized bench for serial_in_stream at default parameters.
// A negedge monitor logs every stb/ack transfer and error pulse; a byte-queue model predicts them.
// All checks are immediate assertions counted in checks/errors.
module tb_serial_in_stream;

    localparam int DIV   = 12000000 / 115200;
    localparam int HALF  = DIV / 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] dout;
    logic        stb;
    logic        fe;
    logic        ov;

    serial_in_stream dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx                  (rx),
        .output_rs232_rx     (dout),
        .output_rs232_rx_stb (stb),
        .output_rs232_rx_ack (ack),
        .framing_error       (fe),
        .overrun             (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Observed activity
    logic [31:0] got[$];
    int          got_cyc[$];
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          rise_cyc = -1;
    logic        stb_q = 1'b0;

    // Reference model state
    logic [7:0]  exp_all[$];
    int          exp_fe = 0;
    int          exp_ov = 0;
    int          checked_idx = 0;

    int checks = 0;
    int errors = 0;

    // Monitor sampling away from the active edge
    always @(negedge clk) begin
        if (stb && !stb_q) rise_cyc = cyc;
        stb_q = stb;
        if (stb && ack) begin
            got.push_back(dout);
            got_cyc.push_back(cyc);
        end
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model: bad stop bit -> framing error; good byte either buffered or overrun when 16 are waiting
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) exp_fe++;
        else if (exp_all.size() - got.size() >= DEPTH) exp_ov++;
        else exp_all.push_back(b);
    endtask

    // Drive one 8N1 frame, LSB first; a low stop bit is left low for the caller
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop_bit;
        tick(DIV);
    endtask

    task automatic send_checked(input logic [7:0] b);
        model_frame(b, 1'b1);
        send_frame(b, 1'b1);
    endtask

    task automatic drain_wait(input int budget);
        int n;
        n = 0;
        while (got.size() < exp_all.size() && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got.size(), exp_all.size());
        for (int i = checked_idx; i < got.size() && i < exp_all.size(); i++)
            check({tag, "_byte"}, got[i], {24'h0, exp_all[i]});
        checked_idx = got.size();
    endtask

    initial begin
        int c0;
        logic [7:0] b;

        // Reset state
        tick(3);
        check("rst_stb", stb, 1'b0);
        check("rst_data", dout, 32'h0);
        check("rst_fe", fe, 1'b0);
        check("rst_ov", ov, 1'b0);
        rst = 1'b0;
        tick(10);

        // Single byte, ack held high; stb rises the cycle after the stop-bit sample
        ack = 1'b1;
        model_frame(8'hA5, 1'b1);
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        drain_wait(50);
        compare_stream("a5");
        check("a5_stb_rise", rise_cyc, c0 + 3 + HALF + 9 * DIV);
        tick(2);
        check("a5_stb_low", stb, 1'b0);

        // Two buffered bytes released back to back
        ack = 1'b0;
        send_checked(8'h55);
        send_checked(8'h0F);
        check("pair_stb", stb, 1'b1);
        check("pair_head", dout, 32'h55);
        tick(5);
        check("pair_head_stable", dout, 32'h55);
        ack = 1'b1;
        drain_wait(20);
        compare_stream("pair");
        if (got_cyc.size() >= 2)
            check("pair_back_to_back", got_cyc[got_cyc.size()-1] - got_cyc[got_cyc.size()-2], 1);
        tick(1);
        check("pair_stb_low", stb, 1'b0);

        // Seventeen random bytes without ack: sixteen kept, one overrun
        ack = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_checked(b);
        end
        tick(4);
        check("ovr_count", ov_cnt, exp_ov);
        check("ovr_stb", stb, 1'b1);
        ack = 1'b1;
        drain_wait(100);
        compare_stream("ovr");
        tick(2);
        check("ovr_stb_low", stb, 1'b0);

        // Stop bit held low, then a break, then recovery with 0x12
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        tick(150);
        rx = 1'b1;
        tick(20);
        check("fe_count", fe_cnt, exp_fe);
        check("fe_no_byte", got.size(), exp_all.size());
        send_checked(8'h12);
        drain_wait(50);
        compare_stream("fe_recover");

        // Short low glitch on an idle line
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(300);
        check("glitch_no_byte", got.size(), exp_all.size());
        check("glitch_fe", fe_cnt, exp_fe);
        check("glitch_ov", ov_cnt, exp_ov);
        b = 8'($urandom);
        send_checked(b);
        drain_wait(50);
        compare_stream("glitch_recover");

        // Reset during bit 4 with two bytes buffered
        ack = 1'b0;
        send_checked(8'($urandom));
        send_checked(8'($urandom));
        check("mid_pre_stb", stb, 1'b1);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(DIV);
        end
        rx = 1'b1;
        tick(DIV / 2);
        rst = 1'b1;
        #1;
        check("mid_rst_stb", stb, 1'b0);
        check("mid_rst_data", dout, 32'h0);
        while (exp_all.size() > got.size()) void'(exp_all.pop_back());
        tick(3);
        rst = 1'b0;
        tick(20);
        ack = 1'b1;
        send_checked(8'h81);
        drain_wait(50);
        compare_stream("mid_rst");
        tick(2);
        check("mid_rst_stb_low", stb, 1'b0);

        // Random traffic with ack high
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_checked(b);
        end
        drain_wait(50);
        compare_stream("rand");

        check("final_fe", fe_cnt, exp_fe);
        check("final_ov", ov_cnt, exp_ov);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
